// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues in-order imem requests, queues responses with their PCs,
// presents them to decode and drops stale responses after a redirect. Option: FETCH_MISALIGN_EN.
module fetch_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
`ifdef FETCH_MISALIGN_EN
    ,
    output logic        if_misalign
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Stale responses can outnumber DEPTH after back-to-back redirects.
    localparam int DW = 8;

    logic [31:0]    pc_q    [DEPTH];
    logic [31:0]    instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
    logic [DEPTH-1:0] mis_q;

    logic [AW-1:0]  head_q, head_d;
    logic [AW-1:0]  fill_q, fill_d;
    logic [AW-1:0]  tail_q, tail_d;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  owed_q, owed_d;
    logic [DW-1:0]  discard_q, discard_d;

    logic full, fire, alloc, alloc_mis, xfer, fill_en, drop_en;

    always_comb begin
        full = (count_q == CW'(DEPTH));
`ifdef FETCH_MISALIGN_EN
        imem_req_valid = !rst && !full && !redirect_valid && (pc[1:0] == 2'b00);
        alloc_mis      = !rst && !full && !redirect_valid && (pc[1:0] != 2'b00);
        imem_req_addr  = pc;
`else
        imem_req_valid = !rst && !full && !redirect_valid;
        alloc_mis      = 1'b0;
        imem_req_addr  = {pc[31:2], 2'b00};
`endif
        fire  = imem_req_valid && imem_req_ready;
        alloc = fire || alloc_mis;

        if (redirect_valid)
            pc_next = redirect_pc;
        else if (fire)
            pc_next = pc + 32'd4;
        else
            pc_next = pc;

        if_valid = !rst && filled_q[head_q] && (count_q != '0) && !redirect_valid;
        if_pc    = pc_q[head_q];
        if_instr = instr_q[head_q];
        xfer     = if_valid && if_ready;

        drop_en = imem_resp_valid && (discard_q != '0);
        fill_en = imem_resp_valid && (discard_q == '0) && (owed_q != '0) && !redirect_valid;
    end

`ifdef FETCH_MISALIGN_EN
    assign if_misalign = if_valid && mis_q[head_q];
`endif

    always_comb begin
        head_d    = head_q;
        fill_d    = fill_q;
        tail_d    = tail_q;
        count_d   = count_q;
        owed_d    = owed_q;
        discard_d = discard_q;
        if (redirect_valid) begin
            head_d  = '0;
            fill_d  = '0;
            tail_d  = '0;
            count_d = '0;
            owed_d  = '0;
            // A response landing now pays off one of the owed/stale responses.
            discard_d = discard_q + DW'(owed_q)
                        - DW'(imem_resp_valid && ((discard_q != '0) || (owed_q != '0)));
        end else begin
            if (drop_en) discard_d = discard_q - 1'b1;
            if (fill_en) fill_d = fill_q + 1'b1;
            if (xfer)    head_d = head_q + 1'b1;
            if (alloc)   tail_d = tail_q + 1'b1;
            count_d = count_q + CW'(alloc) - CW'(xfer);
            owed_d  = owed_q + CW'(fire) - CW'(fill_en);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q    <= '0;
            fill_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            owed_q    <= '0;
            discard_q <= '0;
            filled_q  <= '0;
            mis_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            fill_q    <= fill_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            owed_q    <= owed_d;
            discard_q <= discard_d;
            if (redirect_valid) begin
                filled_q <= '0;
                mis_q    <= '0;
            end else begin
                if (fill_en) begin
                    instr_q[fill_q]  <= imem_resp_data;
                    filled_q[fill_q] <= 1'b1;
                end
                if (xfer) begin
                    filled_q[head_q] <= 1'b0;
                    mis_q[head_q]    <= 1'b0;
                end
                // Misaligned entries are complete at allocation with a zero instruction.
                if (alloc) begin
                    pc_q[tail_q]     <= pc;
                    instr_q[tail_q]  <= '0;
                    filled_q[tail_q] <= alloc_mis;
                    mis_q[tail_q]    <= alloc_mis;
                end
            end
        end
    end

endmodule
